// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential RV32M multiply/divide unit (one-cycle multiply, 32-step restoring divide).
// Define DIV_EARLY_OUT_EN to send divide-by-zero and signed overflow straight from accept to DONE.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MUL   | full product formed this cycle
// DIV   | one restoring-division step per cycle, cnt 31..0
// DONE  | result held until out_ready
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] opa_q, opb_q, rem_q;
  logic            q_neg_q, r_neg_q, div_zero_q;

  logic            accept, early_out;
  logic            in_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;

  assign accept    = in_valid & in_ready & ~flush;
  assign in_signed = ~in_funct3[0];
  assign rs1_neg   = in_signed & in_rs1[XLEN-1];
  assign rs2_neg   = in_signed & in_rs2[XLEN-1];
  assign rs1_mag   = rs1_neg ? -in_rs1 : in_rs1;
  assign rs2_mag   = rs2_neg ? -in_rs2 : in_rs2;

`ifdef DIV_EARLY_OUT_EN
  logic            div_zero_in, div_ovf_in;
  logic [XLEN-1:0] early_result;

  assign div_zero_in = (in_rs2 == '0);
  assign div_ovf_in  = in_signed & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_rs2);
  assign early_out   = in_funct3[2] & (div_zero_in | div_ovf_in);

  // Overflow quotient equals the dividend (0x80000000); overflow remainder is zero.
  always_comb begin
    early_result = '0;
    if (div_zero_in)
      early_result = in_funct3[1] ? in_rs1 : '1;
    else if (!in_funct3[1])
      early_result = in_rs1;
  end
`else
  assign early_out = 1'b0;
`endif

  // Multiply: operands sign- or zero-extended to 2*XLEN; the low 2*XLEN bits are exact.
  logic              a_sext, b_sext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign a_sext  = ((op_q == 2'b01) || (op_q == 2'b10)) & opa_q[XLEN-1];
  assign b_sext  = (op_q == 2'b01) & opb_q[XLEN-1];
  assign prod    = {{XLEN{a_sext}}, opa_q} * {{XLEN{b_sext}}, opb_q};
  assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Divide step: opa_q shifts the dividend out MSB-first while quotient bits shift in.
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff, rem_nx, quo_nx, quo_fix, rem_fix, div_res;

  assign shifted = {rem_q, opa_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, opb_q});
  assign diff    = shifted[XLEN-1:0] - opb_q;
  assign rem_nx  = ge ? diff : shifted[XLEN-1:0];
  assign quo_nx  = {opa_q[XLEN-2:0], ge};
  assign quo_fix = div_zero_q ? '1 : (q_neg_q ? -quo_nx : quo_nx);
  assign rem_fix = r_neg_q ? -rem_nx : rem_nx;
  assign div_res = op_q[1] ? rem_fix : quo_fix;

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) state_d = early_out ? DONE : (in_funct3[2] ? DIV : MUL);
        MUL:  state_d = DONE;
        DIV:  if (cnt_q == '0) state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= 5'd31;
        out_tag <= in_tag;
      end else if (state_q == DIV && cnt_q != '0) begin
        cnt_q <= cnt_q - 5'd1;
      end
`ifdef DIV_EARLY_OUT_EN
      if (accept && early_out) out_result <= early_result;
`endif
      if (state_q == MUL && !flush)
        out_result <= mul_res;
      else if (state_q == DIV && cnt_q == '0 && !flush)
        out_result <= div_res;
    end
  end

  // Operand and working registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= in_funct3[1:0];
      opa_q      <= in_funct3[2] ? rs1_mag : in_rs1;
      opb_q      <= in_funct3[2] ? rs2_mag : in_rs2;
      rem_q      <= '0;
      q_neg_q    <= rs1_neg ^ rs2_neg;
      r_neg_q    <= rs1_neg;
      div_zero_q <= (in_rs2 == '0);
    end else if (state_q == DIV) begin
      opa_q <= quo_nx;
      rem_q <= rem_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases, flush/reset, then random ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  // Presents a request for one edge, then leaves junk on the inputs (must be ignored while busy).
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_rs1    = a;
    in_rs2    = b;
    in_tag    = tag;
    out_ready = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_funct3 = 3'($urandom_range(0, 7));
    in_rs1    = $urandom;
    in_rs2    = $urandom;
    in_tag    = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int hold);
    int          lat;
    logic [31:0] exp;
    exp = ref_model(f3, a, b);
    start_op(f3, a, b, tag);
    wait_valid(lat);
    chk($sformatf("latency f3=%0d", f3), lat, exp_lat(f3, a, b));
    chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), out_result, exp);
    chk("tag", out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", out_result, exp);
      chk("hold_tag", out_tag, tag);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_tag"}, out_tag, 0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen_valid;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'd0; in_rs1 = 32'h0; in_rs2 = 32'h0; in_tag = 5'd0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);   // MULH  -1*-1
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);   // MULHU
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);           // DIV -7/2
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);           // REM -7%2
    do_op(3'd5, 32'd5, 32'd0, 5'd7, 0);                   // DIVU by zero
    do_op(3'd7, 32'd5, 32'd0, 5'd8, 0);                   // REMU by zero
    do_op(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd9, 0);           // DIV negative by zero
    do_op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd10, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0);  // signed overflow
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 0);
    do_op(3'd2, 32'h8000_0001, 32'hF000_0000, 5'd11, 0);  // MULHSU
    do_op(3'd0, 32'h0001_2345, 32'h0006_789A, 5'd12, 10); // stall in DONE

    // Flush at iteration 10 of a divide.
    start_op(3'd4, 32'h1234_5678, 32'd3, 5'd13);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_div_busy", busy, 0);
    chk("flush_div_in_ready", in_ready, 1);
    chk("flush_div_out_valid", out_valid, 0);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_valid |= out_valid;
    end
    chk("flush_no_result", seen_valid, 0);

    // Flush beats an accept in IDLE.
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd0; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept_busy", busy, 0);

    // Flush beats the out_ready handshake in DONE.
    start_op(3'd0, 32'd6, 32'd7, 5'd14);
    wait_valid(lat);
    chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", out_valid, 0);
    chk("flush_done_busy", busy, 0);

    // Asynchronous reset in the middle of a divide.
    start_op(3'd5, 32'hDEAD_BEEF, 32'd7, 5'd15);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_div_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd7, 32'hDEAD_BEEF, 32'd7, 5'd16, 0);

    for (int i = 0; i < 80; i++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
            5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only value 32 is supported.
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port in_funct3  input  3  M-extension op: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
REQ-009 SHALL have port in_rs1  input  XLEN  dividend or multiplicand.
REQ-010 SHALL have port in_rs2  input  XLEN  divisor or multiplier.
REQ-011 SHALL have port in_tag  input  TAG_W  rd tag, returned unchanged.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port out_result  output  XLEN  result.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL use the states IDLE, MUL, DIV and DONE.
REQ-018 SHALL drive in_ready high only in IDLE; a request is accepted on an edge where in_valid, in_ready and !flush are all high.
REQ-019 SHALL on accept latch funct3, operands and tag, then go to MUL for funct3[2]=0 and to DIV for funct3[2]=1.
REQ-020 SHALL in MUL compute the full 64-bit product in one cycle and go to DONE. Operand signedness: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-021 SHALL return low 32 bits for MUL and high 32 bits for MULH/MULHSU/MULHU.
REQ-022 SHALL in DIV run a 32-iteration restoring division on operand magnitudes, one quotient bit per cycle, with a 5-bit counter from 31 down to 0, then go to DONE.
REQ-023 SHALL apply the sign fix on DIV/REM: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
REQ-024 SHALL return, for divisor 0, quotient 0xFFFFFFFF and remainder = rs1, for both signed and unsigned ops.
REQ-025 SHALL return, for DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF, quotient 0x80000000 and remainder 0.
REQ-026 SHALL assert out_valid only in DONE, holding out_result and out_tag stable until out_ready is high.
REQ-027 SHALL on DONE with out_ready high return to IDLE; a new accept is possible on the next edge at earliest.
REQ-028 SHALL give a latency from the accepting edge to the first out_valid cycle of 2 edges for MUL ops and 33 edges for DIV ops.
REQ-029 SHALL on flush return to IDLE on the next edge from any state, drop the result and deassert out_valid; flush takes priority over accept and over an out_ready handshake on the same edge.
REQ-030 SHALL ignore in_valid, in_funct3, in_rs1, in_rs2 and in_tag outside IDLE.

Reset
REQ-031 SHALL on rst_n low immediately force state IDLE, counter 0, out_valid 0, busy 0, in_ready 1, out_result 0 and out_tag 0, including mid-operation.
REQ-032 SHALL leave the internal operand registers undefined after reset.

Configuration
REQ-033 SHALL, when DIV_EARLY_OUT_EN is defined, route divide-by-zero and signed overflow from accept directly to DONE, giving a latency of 1 edge.
REQ-034 SHALL, when DIV_EARLY_OUT_EN is undefined, run those cases for the full 33-edge latency; results are identical in both builds.

Verification
REQ-035 SHALL cover MULH rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0x00000000; MULHU on the same operands -> 0xFFFFFFFE; both with out_valid 2 edges after accept.
REQ-036 SHALL cover DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; both with out_valid 33 edges after accept.
REQ-037 SHALL cover DIVU rs1=5, rs2=0 -> 0xFFFFFFFF and REMU -> 5, at latency 1 with DIV_EARLY_OUT_EN defined and 33 without.
REQ-038 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, with out_tag equal to in_tag.
REQ-039 SHALL cover out_ready held low 10 cycles in DONE -> result stable, in_ready 0, then handshake -> IDLE.
REQ-040 SHALL cover flush at iteration 10 of DIV -> IDLE next edge, no out_valid; reset mid-DIV -> all outputs at reset values.
